// File: rtl/updown_count_checker_pkg.sv
// Shared types and default constants for the up/down counter checker.
// State encodings are visible on the debug port, so they are fixed here.
package updown_count_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ERROR = 2'b10
    } state_e;

    localparam int unsigned DEF_WIDTH      = 3;
    localparam int unsigned DEF_STABLE_CYC = 2;
    localparam int unsigned DEF_WRAP_W     = 8;

endpackage

// File: rtl/updown_count_checker_if.sv
// Signal bundle between the counter/controller side (master) and the checker (slave).
interface updown_count_checker_if
    import updown_count_checker_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned WRAP_W = DEF_WRAP_W
) ();

    logic [WIDTH-1:0]  cnt_in;
    logic              dir;
    logic              clr;
    logic [WIDTH-1:0]  cur_val;
    logic              step_pulse;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic              seq_err;
    state_e            state;

    modport master (
        output cnt_in, dir, clr,
        input  cur_val, step_pulse, wrap_pulse, wrap_count, seq_err, state
    );

    modport slave (
        input  cnt_in, dir, clr,
        output cur_val, step_pulse, wrap_pulse, wrap_count, seq_err, state
    );

endinterface

// File: rtl/updown_count_checker_cnt_sync_filter.sv
// Two-flop synchroniser for the ripple counter bus followed by a stability filter
// that strobes accept_o once a value has been seen unchanged for STABLE_CYC cycles.
module cnt_sync_filter
    import updown_count_checker_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned STABLE_CYC = DEF_STABLE_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] val_o,
    output logic             accept_o
);

    localparam int unsigned SW = $clog2(STABLE_CYC + 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] prev_q;
    logic [SW-1:0]    stab_q;
    logic [SW-1:0]    stab_d;
    logic             same;

    assign same  = (s2_q == prev_q);
    assign val_o = s2_q;

    // Accept is taken from the next-state so it fires in the cycle the count reaches the threshold.
    assign accept_o = same && (stab_q == SW'(STABLE_CYC - 1));

    always_comb begin
        stab_d = stab_q;
        if (!same) begin
            stab_d = '0;
        end else if (stab_q != SW'(STABLE_CYC)) begin
            stab_d = stab_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            stab_q <= '0;
        end else begin
            s1_q   <= val_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            stab_q <= stab_d;
        end
    end

endmodule

// File: rtl/updown_count_checker.sv
// Checks a resynchronised ripple up/down counter for legal +/-1 steps, reporting
// step/wrap pulses, a saturating wrap tally and a sticky sequence error.
module updown_count_checker
    import updown_count_checker_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
    parameter int unsigned WRAP_W     = DEF_WRAP_W
) (
    input logic                   clk,
    input logic                   rst,
    updown_count_checker_if.slave bus
);

    logic [WIDTH-1:0]  filt_val;
    logic              accept;
    logic              dir_s1_q;
    logic              dir_s2_q;
    logic              dir_prev_q;
    logic              dir_chg;

    state_e            state_q;
    state_e            state_d;
    logic [WIDTH-1:0]  cur_val_q;
    logic [WIDTH-1:0]  cur_val_d;
    logic              step_q;
    logic              step_d;
    logic              wrap_q;
    logic              wrap_d;
    logic [WRAP_W-1:0] wrap_cnt_q;
    logic [WRAP_W-1:0] wrap_cnt_d;
    logic              err_q;
    logic              err_d;

    logic [WIDTH-1:0]  up_val;
    logic [WIDTH-1:0]  dn_val;
    logic [WRAP_W-1:0] wrap_inc;

    cnt_sync_filter #(
        .WIDTH      (WIDTH),
        .STABLE_CYC (STABLE_CYC)
    ) u_cnt_filter (
        .clk      (clk),
        .rst      (rst),
        .val_i    (bus.cnt_in),
        .val_o    (filt_val),
        .accept_o (accept)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_s1_q   <= 1'b0;
            dir_s2_q   <= 1'b0;
            dir_prev_q <= 1'b0;
        end else begin
            dir_s1_q   <= bus.dir;
            dir_s2_q   <= dir_s1_q;
            dir_prev_q <= dir_s2_q;
        end
    end

    assign dir_chg  = dir_s2_q ^ dir_prev_q;
    assign up_val   = cur_val_q + 1'b1;
    assign dn_val   = cur_val_q - 1'b1;
    assign wrap_inc = (&wrap_cnt_q) ? wrap_cnt_q : wrap_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cur_val_d  = cur_val_q;
        step_d     = 1'b0;
        wrap_d     = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        err_d      = err_q;

        if (bus.clr) begin
            state_d    = IDLE;
            cur_val_d  = '0;
            wrap_cnt_d = '0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cur_val_d = filt_val;
                        state_d   = TRACK;
                    end
                end
                TRACK: begin
                    // A mode change re-arms; a value accepted alongside it is loaded unchecked.
                    if (dir_chg) begin
                        state_d = IDLE;
                        if (accept) begin
                            cur_val_d = filt_val;
                        end
                    end else if (accept) begin
                        cur_val_d = filt_val;
                        if (filt_val != cur_val_q) begin
                            if (dir_s2_q && (filt_val == up_val)) begin
                                step_d = 1'b1;
                                if (&cur_val_q) begin
                                    wrap_d     = 1'b1;
                                    wrap_cnt_d = wrap_inc;
                                end
                            end else if (!dir_s2_q && (filt_val == dn_val)) begin
                                step_d = 1'b1;
                                if (~|cur_val_q) begin
                                    wrap_d     = 1'b1;
                                    wrap_cnt_d = wrap_inc;
                                end
                            end else begin
                                err_d   = 1'b1;
                                state_d = ERROR;
                            end
                        end
                    end
                end
                ERROR: begin
                    if (accept) begin
                        cur_val_d = filt_val;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cur_val_q  <= '0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_val_q  <= cur_val_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.cur_val    = cur_val_q;
    assign bus.step_pulse = step_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.wrap_count = wrap_cnt_q;
    assign bus.seq_err    = err_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_updown_count_checker.sv
// Self-checking bench: two checkers (8-bit and 2-bit wrap tally) share one stimulus
// stream, compared against a transaction-level model of the checking rules.
module tb_updown_count_checker;
    import updown_count_checker_pkg::*;

    localparam int M_IDLE  = 0;
    localparam int M_TRACK = 1;
    localparam int M_ERROR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cnt_in;
    logic       dir;
    logic       clr;

    int checks   = 0;
    int failures = 0;

    int   n_steps = 0;
    int   n_wraps = 0;
    int   n_bad   = 0;
    logic prev_step = 1'b0;

    int m_st, m_cur, m_wc8, m_wc2, m_err, m_dir, m_last;
    int exp_steps = 0;
    int exp_wraps = 0;

    always #5 clk = ~clk;

    updown_count_checker_if #(.WIDTH(3), .WRAP_W(8)) bus ();
    updown_count_checker_if #(.WIDTH(3), .WRAP_W(2)) bus_s ();

    assign bus.cnt_in   = cnt_in;
    assign bus.dir      = dir;
    assign bus.clr      = clr;
    assign bus_s.cnt_in = cnt_in;
    assign bus_s.dir    = dir;
    assign bus_s.clr    = clr;

    updown_count_checker #(.WIDTH(3), .STABLE_CYC(2), .WRAP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    updown_count_checker #(.WIDTH(3), .STABLE_CYC(2), .WRAP_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    // Pulse monitor: tallies pulses and flags back-to-back steps or a wrap without a step.
    always @(posedge clk) begin
        #1;
        if (bus.step_pulse === 1'b1) n_steps++;
        if (bus.wrap_pulse === 1'b1) n_wraps++;
        if ((bus.step_pulse === 1'b1 && prev_step) || (bus.wrap_pulse === 1'b1 && bus.step_pulse !== 1'b1))
            n_bad++;
        prev_step = (bus.step_pulse === 1'b1);
    end

    function automatic void model_reset();
        m_st = M_IDLE; m_cur = 0; m_wc8 = 0; m_wc2 = 0; m_err = 0; m_dir = 0; m_last = -1;
    endfunction

    function automatic void model_clr();
        m_st = M_IDLE; m_cur = 0; m_wc8 = 0; m_wc2 = 0; m_err = 0;
    endfunction

    function automatic void model_dir(int d);
        if (d != m_dir && m_st == M_TRACK) m_st = M_IDLE;
        m_dir = d;
    endfunction

    function automatic void model_wrap();
        exp_wraps++;
        m_wc8 = (m_wc8 < 255) ? m_wc8 + 1 : 255;
        m_wc2 = (m_wc2 < 3) ? m_wc2 + 1 : 3;
    endfunction

    function automatic void model_accept(int v);
        if (m_st == M_IDLE) begin
            m_st = M_TRACK;
        end else if (m_st == M_TRACK && v != m_cur) begin
            if (m_dir == 1 && v == (m_cur + 1) % 8) begin
                exp_steps++;
                if (m_cur == 7) model_wrap();
            end else if (m_dir == 0 && v == (m_cur + 7) % 8) begin
                exp_steps++;
                if (m_cur == 0) model_wrap();
            end else begin
                m_err = 1;
                m_st  = M_ERROR;
            end
        end
        m_cur = v;
    endfunction

    task automatic drive(input int v, input int hold);
        cnt_in = 3'(v);
        repeat (hold) @(negedge clk);
        if (v != m_last) model_accept(v);
        m_last = v;
    endtask

    task automatic set_dir(input logic d);
        dir = d;
        repeat (5) @(negedge clk);
        model_dir(int'(d));
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        model_clr();
    endtask

    task automatic test_reset();
        rst = 1'b0; cnt_in = '0; dir = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.cur_val, bus.step_pulse, bus.wrap_pulse, bus.wrap_count, bus.seq_err, bus.state} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got cur=%0d wc=%0d err=%0b st=%0d want all 0",
                     bus.cur_val, bus.wrap_count, bus.seq_err, bus.state);
        end
        rst = 1'b1;
        model_reset();
        drive(0, 6);
        checks++;
        if (bus.state !== 2'(m_st)) begin failures++; $display("FAIL arm_state got=%0d exp=%0d", bus.state, m_st); end
        checks++;
        if (bus.cur_val !== 3'(m_cur)) begin failures++; $display("FAIL arm_cur got=%0d exp=%0d", bus.cur_val, m_cur); end
        checks++;
        if (n_steps != exp_steps || n_wraps != exp_wraps) begin
            failures++; $display("FAIL arm_pulses got=%0d/%0d exp=%0d/%0d", n_steps, n_wraps, exp_steps, exp_wraps);
        end
        checks++;
        if (bus.seq_err !== 1'b0) begin failures++; $display("FAIL arm_err got=%0b exp=0", bus.seq_err); end
    endtask

    task automatic test_up();
        int s0, w0;
        set_dir(1'b1);
        checks++;
        if (bus.state !== 2'(m_st)) begin failures++; $display("FAIL up_rearm_state got=%0d exp=%0d", bus.state, m_st); end
        drive(7, 6);
        s0 = n_steps; w0 = n_wraps;
        for (int i = 0; i < 8; i++) drive(i, int'($urandom_range(6, 10)));
        checks++;
        if (n_steps - s0 != 8) begin failures++; $display("FAIL up_steps got=%0d exp=8", n_steps - s0); end
        checks++;
        if (n_wraps - w0 != 1) begin failures++; $display("FAIL up_wraps got=%0d exp=1", n_wraps - w0); end
        checks++;
        if (bus.wrap_count !== 8'(m_wc8) || m_wc8 != 1) begin
            failures++; $display("FAIL up_wrap_count got=%0d exp=1", bus.wrap_count);
        end
        checks++;
        if (bus.seq_err !== 1'b0 || bus.cur_val !== 3'd7) begin
            failures++; $display("FAIL up_final got err=%0b cur=%0d exp err=0 cur=7", bus.seq_err, bus.cur_val);
        end
    endtask

    task automatic test_down();
        int s0, w0;
        set_dir(1'b0);
        drive(0, 6);
        s0 = n_steps; w0 = n_wraps;
        for (int i = 7; i >= 0; i--) drive(i, int'($urandom_range(6, 10)));
        checks++;
        if (n_steps - s0 != 8) begin failures++; $display("FAIL down_steps got=%0d exp=8", n_steps - s0); end
        checks++;
        if (n_wraps - w0 != 1) begin failures++; $display("FAIL down_wraps got=%0d exp=1", n_wraps - w0); end
        checks++;
        if (bus.wrap_count !== 8'd2) begin failures++; $display("FAIL down_wrap_count got=%0d exp=2", bus.wrap_count); end
        checks++;
        if (bus.state !== 2'(m_st) || bus.cur_val !== 3'(m_cur)) begin
            failures++; $display("FAIL down_final got st=%0d cur=%0d exp st=%0d cur=%0d", bus.state, bus.cur_val, m_st, m_cur);
        end
    endtask

    task automatic test_glitch();
        int s0, g;
        set_dir(1'b1);
        drive(3, 6);
        s0 = n_steps;
        for (int k = 0; k < 6; k++) begin
            g = int'($urandom_range(0, 7));
            if (g == 3) g = 4;
            cnt_in = 3'(g);
            repeat (int'($urandom_range(1, 2))) @(negedge clk);
            cnt_in = 3'd3;
            repeat (6) @(negedge clk);
        end
        checks++;
        if (n_steps != s0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", n_steps - s0); end
        checks++;
        if (bus.seq_err !== 1'b0) begin failures++; $display("FAIL glitch_err got=%0b exp=0", bus.seq_err); end
        checks++;
        if (bus.cur_val !== 3'd3 || bus.state !== 2'(M_TRACK)) begin
            failures++; $display("FAIL glitch_hold got cur=%0d st=%0d exp cur=3 st=1", bus.cur_val, bus.state);
        end
    endtask

    task automatic test_illegal();
        int s0;
        do_clr();
        checks++;
        if (bus.state !== 2'(M_IDLE) || bus.cur_val !== 3'd0 || bus.wrap_count !== 8'd0) begin
            failures++; $display("FAIL clr1 got st=%0d cur=%0d wc=%0d exp 0/0/0", bus.state, bus.cur_val, bus.wrap_count);
        end
        drive(2, 7);
        drive(4, 7);
        checks++;
        if (bus.seq_err !== 1'b1 || bus.state !== 2'(M_ERROR)) begin
            failures++; $display("FAIL illegal_err got err=%0b st=%0d exp err=1 st=2", bus.seq_err, bus.state);
        end
        s0 = n_steps;
        drive(5, 7);
        drive(6, 7);
        checks++;
        if (n_steps != s0 || bus.cur_val !== 3'(m_cur) || bus.state !== 2'(m_st)) begin
            failures++; $display("FAIL error_hold got steps=%0d cur=%0d st=%0d exp 0/%0d/%0d", n_steps - s0, bus.cur_val, bus.state, m_cur, m_st);
        end
        do_clr();
        checks++;
        if (bus.state !== 2'(M_IDLE) || bus.seq_err !== 1'b0 || bus.wrap_count !== 8'd0) begin
            failures++; $display("FAIL clr2 got st=%0d err=%0b wc=%0d exp 0/0/0", bus.state, bus.seq_err, bus.wrap_count);
        end
    endtask

    task automatic test_simultaneous();
        drive(7, 7);
        cnt_in = 3'd2;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        model_clr(); m_last = 2;
        checks++;
        if (bus.state !== 2'(m_st) || bus.cur_val !== 3'(m_cur) || bus.seq_err !== 1'b0) begin
            failures++; $display("FAIL clr_vs_accept got st=%0d cur=%0d err=%0b exp st=0 cur=0 err=0", bus.state, bus.cur_val, bus.seq_err);
        end
        drive(5, 7);
        cnt_in = 3'd0;
        repeat (2) @(negedge clk);
        dir = 1'b0;
        repeat (6) @(negedge clk);
        m_st = M_IDLE; m_cur = 0; m_dir = 0; m_last = 0;
        checks++;
        if (bus.state !== 2'(m_st) || bus.cur_val !== 3'(m_cur) || bus.seq_err !== 1'b0) begin
            failures++; $display("FAIL dir_vs_accept got st=%0d cur=%0d err=%0b exp st=0 cur=0 err=0", bus.state, bus.cur_val, bus.seq_err);
        end
        checks++;
        if (n_steps != exp_steps) begin failures++; $display("FAIL simul_pulses got=%0d exp=%0d", n_steps, exp_steps); end
    endtask

    task automatic test_back_to_back();
        int s0, w0;
        int seq [8] = '{0, 7, 6, 5, 4, 3, 2, 1};
        drive(1, 6);
        s0 = n_steps; w0 = n_wraps;
        foreach (seq[i]) drive(seq[i], 3);
        repeat (6) @(negedge clk);
        checks++;
        if (n_steps - s0 != 8) begin failures++; $display("FAIL b2b_steps got=%0d exp=8", n_steps - s0); end
        checks++;
        if (n_wraps - w0 != 1) begin failures++; $display("FAIL b2b_wraps got=%0d exp=1", n_wraps - w0); end
        checks++;
        if (n_bad != 0) begin failures++; $display("FAIL pulse_shape got=%0d exp=0", n_bad); end
        checks++;
        if (bus.cur_val !== 3'(m_cur) || bus.state !== 2'(m_st)) begin
            failures++; $display("FAIL b2b_final got cur=%0d st=%0d exp cur=%0d st=%0d", bus.cur_val, bus.state, m_cur, m_st);
        end
    endtask

    task automatic test_random();
        int r, v;
        for (int it = 0; it < 60; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                do_clr();
            end else if (r == 1) begin
                set_dir(~dir);
            end else begin
                if (r == 2) v = int'($urandom_range(0, 7));
                else        v = (m_dir == 1) ? (m_cur + 1) % 8 : (m_cur + 7) % 8;
                drive(v, int'($urandom_range(6, 10)));
            end
            checks++;
            if (bus.state !== 2'(m_st) || bus.cur_val !== 3'(m_cur) || bus.seq_err !== 1'(m_err)) begin
                failures++;
                $display("FAIL rand_state it=%0d got st=%0d cur=%0d err=%0b exp st=%0d cur=%0d err=%0d",
                         it, bus.state, bus.cur_val, bus.seq_err, m_st, m_cur, m_err);
            end
            checks++;
            if (bus.wrap_count !== 8'(m_wc8) || bus_s.wrap_count !== 2'(m_wc2)) begin
                failures++;
                $display("FAIL rand_wc it=%0d got=%0d/%0d exp=%0d/%0d", it, bus.wrap_count, bus_s.wrap_count, m_wc8, m_wc2);
            end
            checks++;
            if (n_steps != exp_steps || n_wraps != exp_wraps) begin
                failures++;
                $display("FAIL rand_pulses it=%0d got=%0d/%0d exp=%0d/%0d", it, n_steps, n_wraps, exp_steps, exp_wraps);
            end
        end
    endtask

    task automatic test_saturation();
        do_clr();
        set_dir(1'b1);
        for (int rep = 0; rep < 5; rep++) begin
            for (int v = 0; v < 8; v++) drive(v, 6);
        end
        drive(0, 6);
        checks++;
        if (bus_s.wrap_count !== 2'd3 || m_wc2 != 3) begin
            failures++; $display("FAIL sat_wc2 got=%0d exp=3", bus_s.wrap_count);
        end
        checks++;
        if (bus.wrap_count !== 8'd5 || m_wc8 != 5) begin
            failures++; $display("FAIL sat_wc8 got=%0d exp=5", bus.wrap_count);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.cur_val, bus.step_pulse, bus.wrap_pulse, bus.wrap_count, bus.seq_err, bus.state} !== '0 ||
            {bus_s.wrap_count, bus_s.state, bus_s.cur_val} !== '0) begin
            failures++;
            $display("FAIL async_reset got cur=%0d wc=%0d wc2=%0d st=%0d want all 0",
                     bus.cur_val, bus.wrap_count, bus_s.wrap_count, bus.state);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        drive(3, 8);
        checks++;
        if (bus.state !== 2'(m_st) || bus.cur_val !== 3'(m_cur) || bus.wrap_count !== 8'd0) begin
            failures++; $display("FAIL post_reset_arm got st=%0d cur=%0d wc=%0d exp st=1 cur=3 wc=0", bus.state, bus.cur_val, bus.wrap_count);
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_glitch();
        test_illegal();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
